checkpoint_column_manager: RTL and testbench
============================================

# checkpoint_column_manager

Allocates, tracks and releases the `CHECKPOINT_COLUMNS` checkpoint columns shared by the phys reg map table and the phys reg free list. Dispatch requests a column for each BRU instruction. BRU resolution either retires the column in order or triggers a restore, which squashes every younger column. The block sits between dispatch, the BRU, and the checkpointed structures, and is the sole owner of column occupancy.

## Interface
Parameters:
- `CHECKPOINT_COLUMNS`, default 4: number of columns; must be a power of 2.
- `LOG_CHECKPOINT_COLUMNS`, default `$clog2(CHECKPOINT_COLUMNS)`: column index width.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `flush` in 1: full pipeline flush (ROB revert or halt); frees all columns.
- `save_req` in 1: dispatch wants a checkpoint this cycle.
- `save_ready` out 1: a column is free and a save is accepted this cycle.
- `save_column` out `LOG_CHECKPOINT_COLUMNS`: column to snapshot into (`checkpoint_column_t`).
- `resolve_valid` in 1: BRU resolved a branch this cycle.
- `resolve_column` in `LOG_CHECKPOINT_COLUMNS`: the branch's `checkpoint_safe_column`.
- `resolve_mispredict` in 1: branch mispredicted; restore from `resolve_column`.
- `restore_valid` out 1: registered one-cycle pulse; map table and free list restore now.
- `restore_column` out `LOG_CHECKPOINT_COLUMNS`: column to restore from.
- `column_valid` out `CHECKPOINT_COLUMNS`: per-column allocated bit.
- `occupancy` out `LOG_CHECKPOINT_COLUMNS+1`: allocated column count.

## Operation
State:
- `head_ptr` and `tail_ptr`: each `LOG_CHECKPOINT_COLUMNS+1` bits, with an extra MSB wrap bit.
- `valid[]` and `resolved[]` bit vectors.
- `restore_valid_r` and `restore_column_r`.

Derived signals:
- `occupancy = tail_ptr - head_ptr`, computed modulo 2^(LOG+1).
- Full when `occupancy == CHECKPOINT_COLUMNS`.

Save path:
- `save_column = tail_ptr[LOG-1:0]` (combinational).
- `save_ready = !full && !flush && !(resolve_valid && resolve_mispredict)`.
- On `save_req && save_ready`: set `valid[tail]`, clear `resolved[tail]`, then `tail_ptr++`.

Correct resolve (`resolve_valid && !resolve_mispredict`):
- If `valid[resolve_column]`, set `resolved[resolve_column]`.
- A resolve to an invalid column is ignored.

Release:
- Each cycle, if `valid[head] && resolved[head]` (registered bits), clear `valid[head]` and `head_ptr++`.
- At most one column is released per cycle, always in order.

Mispredict (`resolve_valid && resolve_mispredict && valid[resolve_column]`):
- Clear `valid` and `resolved` for `resolve_column` through `tail-1`, inclusive, following wrap order.
- `tail_ptr` gets the index `resolve_column`. Its wrap bit is `head_ptr[MSB]` if `resolve_column >= head_ptr[LOG-1:0]`, else `~head_ptr[MSB]`.
- Register `restore_valid <= 1` and `restore_column <= resolve_column`.
- A mispredict to an invalid column is ignored: no restore and no state change.

Same-cycle release and mispredict:
- If the head release and a mispredict on a younger column occur together, both take effect.
- A mispredict on the head column empties the queue (`tail = head`); the head release is suppressed.

Priority:
- `RST` > `flush` > mispredict > (save, correct resolve, release; these are concurrent and independent).

Flush:
- Clears all `valid` and `resolved` bits and sets `head = tail = 0`.
- No restore pulse; any pending `restore_valid` is cleared next edge.

## Timing
- Reset values: `head_ptr = tail_ptr = 0`, all `valid`/`resolved` = 0.
- Outputs after reset: `save_ready = 1`, `save_column = 0`, `restore_valid = 0`, `restore_column = 0`, `column_valid = 0`, `occupancy = 0`.
- Save: `save_column` is valid in the request cycle. `column_valid` and `occupancy` update at the next edge.
- Correct resolve: resolved at edge N. If it is the head, it is released at edge N+1 and `save_ready` can reassert in cycle N+1.
- Mispredict: state is squashed at edge N. `restore_valid` is high for exactly the cycle after edge N. Saves are accepted in that same cycle, at the new tail.
- Wrap-around: pointer indices wrap modulo `CHECKPOINT_COLUMNS`. The MSB distinguishes full from empty.
- `RST` asserted mid-operation: all state is cleared at that edge, and any in-flight restore pulse is dropped.

## Test plan
- Reset, then 4 back-to-back saves: `save_column` = 0,1,2,3. After the 4th, `save_ready = 0` and `occupancy = 4`. A 5th `save_req` is ignored.
- Resolve columns 0,1,2,3 correct on consecutive cycles: each is released one cycle after its resolve, `occupancy` steps down to 0, and the next save gets column 0 with the pointer wrapped (MSB = 1).
- Out-of-order resolve, with 0–3 allocated: resolve 2, then 1, then 0. Column 0 frees one cycle after its resolve; 1 and 2 then free on the following consecutive cycles.
- Mispredict on column 1 with 0–3 allocated: `column_valid` goes to 0001, `occupancy` to 1. `restore_valid` pulses once with `restore_column = 1`. The next save gets column 1.
- Same-cycle `save_req` and mispredict on column 2: `save_ready = 0` and the save is not accepted. The following cycle's save gets column 2.
- With 3 columns allocated, `flush` together with a mispredict and a save: all columns are freed, no `restore_valid`, `occupancy = 0`. With 2 allocated, `RST` the cycle after a mispredict: `restore_valid` stays 0 and `occupancy = 0`.

Source files
------------

// File: rtl/checkpoint_column_manager.sv
// checkpoint_column_manager
//   Owns occupancy of the checkpoint columns shared by the phys reg map table
//   and the phys reg free list. Columns are allocated in order at dispatch
//   (one per BRU instruction), retired in order once resolved correctly, and
//   squashed from the mispredicted column through the youngest on a restore.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   flush               full pipeline flush; frees every column, no restore
//   save_req            dispatch requests a column this cycle
//   save_ready          save accepted this cycle (column free, no flush/mispredict)
//   save_column         column to snapshot into (valid in the request cycle)
//   resolve_valid       BRU resolved a branch this cycle
//   resolve_column      column the branch was saved into
//   resolve_mispredict  branch mispredicted; restore from resolve_column
//   restore_valid       registered one-cycle restore pulse
//   restore_column      column to restore from
//   column_valid        per-column allocated bits
//   occupancy           number of allocated columns
module checkpoint_column_manager #(
    parameter int CHECKPOINT_COLUMNS     = 4,
    parameter int LOG_CHECKPOINT_COLUMNS = $clog2(CHECKPOINT_COLUMNS)
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              flush,
    input  logic                              save_req,
    output logic                              save_ready,
    output logic [LOG_CHECKPOINT_COLUMNS-1:0] save_column,
    input  logic                              resolve_valid,
    input  logic [LOG_CHECKPOINT_COLUMNS-1:0] resolve_column,
    input  logic                              resolve_mispredict,
    output logic                              restore_valid,
    output logic [LOG_CHECKPOINT_COLUMNS-1:0] restore_column,
    output logic [CHECKPOINT_COLUMNS-1:0]     column_valid,
    output logic [LOG_CHECKPOINT_COLUMNS:0]   occupancy
);

    localparam int N = CHECKPOINT_COLUMNS;
    localparam int L = LOG_CHECKPOINT_COLUMNS;

    typedef logic [L-1:0] checkpoint_column_t;
    typedef logic [L:0]   checkpoint_ptr_t;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    checkpoint_ptr_t    head_ptr, tail_ptr;
    checkpoint_ptr_t    head_nxt, tail_nxt;
    logic [N-1:0]       valid, resolved;
    logic [N-1:0]       valid_nxt, resolved_nxt;
    logic               restore_valid_r;
    checkpoint_column_t restore_column_r;

    checkpoint_column_t head_idx, tail_idx, rc_age;
    logic               full, save_fire, release_head, mispredict, correct;
    logic [N-1:0]       squash;
    checkpoint_ptr_t    mp_tail;

    assign head_idx     = head_ptr[L-1:0];
    assign tail_idx     = tail_ptr[L-1:0];
    assign occupancy    = tail_ptr - head_ptr;
    assign full         = (occupancy == (L+1)'(N));

    assign save_column  = tail_idx;
    assign save_ready   = !full && !flush && !(resolve_valid && resolve_mispredict);
    assign save_fire    = save_req && save_ready;

    assign release_head = valid[head_idx] && resolved[head_idx];
    assign mispredict   = resolve_valid && resolve_mispredict && valid[resolve_column];
    assign correct      = resolve_valid && !resolve_mispredict && valid[resolve_column];

    // Age of a column relative to head; everything at least as young as the
    // mispredicted column (and still allocated) is squashed.
    assign rc_age = resolve_column - head_idx;

    for (genvar g = 0; g < N; g++) begin : g_col
        localparam checkpoint_column_t IDX = L'(g);
        checkpoint_column_t age;
        assign age       = IDX - head_idx;
        assign squash[g] = valid[g] && (age >= rc_age);
    end

    // New tail lands on the mispredicted column; its wrap bit follows head
    // unless the column index has wrapped past the end relative to head.
    assign mp_tail = {(resolve_column >= head_idx) ? head_ptr[L] : ~head_ptr[L],
                      resolve_column};

    always_comb begin
        valid_nxt    = valid;
        resolved_nxt = resolved;
        head_nxt     = head_ptr;
        tail_nxt     = tail_ptr;
        if (flush) begin
            valid_nxt    = '0;
            resolved_nxt = '0;
            head_nxt     = '0;
            tail_nxt     = '0;
        end else if (mispredict) begin
            valid_nxt    = valid & ~squash;
            resolved_nxt = resolved & ~squash;
            tail_nxt     = mp_tail;
            // A mispredict on the head itself empties the queue; the head is
            // already squashed, so its release must not advance head.
            if (release_head && (resolve_column != head_idx)) begin
                valid_nxt[head_idx] = 1'b0;
                head_nxt            = head_ptr + (L+1)'(1);
            end
        end else begin
            if (save_fire) begin
                valid_nxt[tail_idx]    = 1'b1;
                resolved_nxt[tail_idx] = 1'b0;
                tail_nxt               = tail_ptr + (L+1)'(1);
            end
            if (correct)
                resolved_nxt[resolve_column] = 1'b1;
            if (release_head) begin
                valid_nxt[head_idx] = 1'b0;
                head_nxt            = head_ptr + (L+1)'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_ptr         <= '0;
            tail_ptr         <= '0;
            valid            <= '0;
            resolved         <= '0;
            restore_valid_r  <= 1'b0;
            restore_column_r <= '0;
        end else begin
            head_ptr        <= head_nxt;
            tail_ptr        <= tail_nxt;
            valid           <= valid_nxt;
            resolved        <= resolved_nxt;
            restore_valid_r <= !flush && mispredict;
            if (!flush && mispredict)
                restore_column_r <= resolve_column;
        end
    end

    assign restore_valid  = restore_valid_r;
    assign restore_column = restore_column_r;
    assign column_valid   = valid;

endmodule

// File: tb/tb_checkpoint_column_manager.sv
module tb_checkpoint_column_manager;

    logic       CLK = 1'b0;
    logic       RST;
    logic       flush;
    logic       save_req;
    logic       save_ready;
    logic [1:0] save_column;
    logic       resolve_valid;
    logic [1:0] resolve_column;
    logic       resolve_mispredict;
    logic       restore_valid;
    logic [1:0] restore_column;
    logic [3:0] column_valid;
    logic [2:0] occupancy;

    int checks = 0;
    int fails  = 0;

    checkpoint_column_manager #(.CHECKPOINT_COLUMNS(4)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .save_req(save_req), .save_ready(save_ready), .save_column(save_column),
        .resolve_valid(resolve_valid), .resolve_column(resolve_column),
        .resolve_mispredict(resolve_mispredict),
        .restore_valid(restore_valid), .restore_column(restore_column),
        .column_valid(column_valid), .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; flush = 1'b0; save_req = 1'b0;
        resolve_valid = 1'b0; resolve_column = 2'd0; resolve_mispredict = 1'b0;
        tick();
        RST = 1'b0;
        settle();
    endtask

    task automatic resolve(input logic [1:0] col, input logic mp);
        resolve_valid = 1'b1; resolve_column = col; resolve_mispredict = mp;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_save_ready", save_ready, 1);
        chk("rst_save_column", save_column, 0);
        chk("rst_restore_valid", restore_valid, 0);
        chk("rst_restore_column", restore_column, 0);
        chk("rst_column_valid", column_valid, 0);
        chk("rst_occupancy", occupancy, 0);

        // four back-to-back saves, fifth rejected
        save_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("fill_save_column", save_column, k);
            chk("fill_save_ready", save_ready, 1);
            tick();
        end
        settle();
        chk("full_save_ready", save_ready, 0);
        chk("full_occupancy", occupancy, 4);
        chk("full_column_valid", column_valid, 4'b1111);
        tick();
        chk("fifth_save_ignored", occupancy, 4);
        save_req = 1'b0;

        // in-order correct resolves, one release per cycle behind
        resolve(2'd0, 1'b0); tick(); chk("inorder_occ_e0", occupancy, 4);
        resolve(2'd1, 1'b0); tick(); chk("inorder_occ_e1", occupancy, 3);
        resolve(2'd2, 1'b0); tick(); chk("inorder_occ_e2", occupancy, 2);
        resolve(2'd3, 1'b0); tick(); chk("inorder_occ_e3", occupancy, 1);
        resolve_valid = 1'b0; tick();
        chk("inorder_occ_e4", occupancy, 0);
        chk("inorder_cv_e4", column_valid, 0);
        save_req = 1'b1; settle();
        chk("wrap_save_column", save_column, 0);
        chk("wrap_save_ready", save_ready, 1);
        tick();
        chk("wrap_occ", occupancy, 1);
        chk("wrap_cv", column_valid, 4'b0001);
        tick(); tick(); tick();
        chk("wrap_full_occ", occupancy, 4);
        chk("wrap_full_ready", save_ready, 0);
        save_req = 1'b0;

        // out-of-order resolve 2,1,0
        do_reset();
        save_req = 1'b1; tick(); tick(); tick(); tick(); save_req = 1'b0;
        resolve(2'd2, 1'b0); tick(); chk("ooo_occ_a", occupancy, 4);
        resolve(2'd1, 1'b0); tick(); chk("ooo_occ_b", occupancy, 4);
        resolve(2'd0, 1'b0); tick(); chk("ooo_occ_c", occupancy, 4);
        resolve_valid = 1'b0;
        tick(); chk("ooo_cv_d", column_valid, 4'b1110);
        tick(); chk("ooo_cv_e", column_valid, 4'b1100);
        tick(); chk("ooo_cv_f", column_valid, 4'b1000);
        chk("ooo_occ_f", occupancy, 1);

        // mispredict on column 1 with 0-3 allocated
        do_reset();
        save_req = 1'b1; tick(); tick(); tick(); tick(); save_req = 1'b0;
        resolve(2'd1, 1'b1); settle();
        chk("mp1_save_ready", save_ready, 0);
        tick();
        chk("mp1_cv", column_valid, 4'b0001);
        chk("mp1_occ", occupancy, 1);
        chk("mp1_restore_valid", restore_valid, 1);
        chk("mp1_restore_column", restore_column, 1);
        resolve_valid = 1'b0; save_req = 1'b1; settle();
        chk("mp1_next_save_column", save_column, 1);
        chk("mp1_next_save_ready", save_ready, 1);
        tick();
        chk("mp1_pulse_end", restore_valid, 0);
        chk("mp1_cv_after_save", column_valid, 4'b0011);
        save_req = 1'b0;

        // same-cycle save and mispredict on column 2
        save_req = 1'b1; tick();
        chk("mp2_pre_cv", column_valid, 4'b0111);
        resolve(2'd2, 1'b1); settle();
        chk("mp2_save_ready", save_ready, 0);
        tick();
        chk("mp2_cv", column_valid, 4'b0011);
        chk("mp2_occ", occupancy, 2);
        chk("mp2_restore_column", restore_column, 2);
        resolve_valid = 1'b0; settle();
        chk("mp2_next_save_column", save_column, 2);
        tick();
        chk("mp2_cv_after", column_valid, 4'b0111);
        save_req = 1'b0;

        // flush together with mispredict and save, 3 allocated
        flush = 1'b1; save_req = 1'b1; resolve(2'd1, 1'b1); settle();
        chk("flush_save_ready", save_ready, 0);
        tick();
        chk("flush_cv", column_valid, 0);
        chk("flush_occ", occupancy, 0);
        chk("flush_no_restore", restore_valid, 0);
        flush = 1'b0; save_req = 1'b0; resolve_valid = 1'b0; settle();
        chk("flush_save_column", save_column, 0);

        // RST in the restore cycle drops the pulse
        save_req = 1'b1; tick(); tick(); save_req = 1'b0;
        resolve(2'd1, 1'b1); tick();
        chk("rstmp_restore_valid", restore_valid, 1);
        chk("rstmp_occ", occupancy, 1);
        resolve_valid = 1'b0; RST = 1'b1; tick(); RST = 1'b0;
        chk("rstmp_restore_dropped", restore_valid, 0);
        chk("rstmp_occ_after", occupancy, 0);

        // mispredict to an unallocated column is ignored
        save_req = 1'b1; tick(); save_req = 1'b0;
        resolve(2'd3, 1'b1); tick();
        chk("inv_mp_restore", restore_valid, 0);
        chk("inv_mp_occ", occupancy, 1);
        resolve_valid = 1'b0;

        // mispredict on head while head is releasing: queue empties
        save_req = 1'b1; tick(); save_req = 1'b0;
        resolve(2'd0, 1'b0); tick();
        resolve(2'd0, 1'b1); tick();
        chk("headmp_occ", occupancy, 0);
        chk("headmp_cv", column_valid, 0);
        chk("headmp_restore_column", restore_column, 0);
        resolve_valid = 1'b0;

        // mispredict on younger column concurrent with head release
        save_req = 1'b1; tick(); tick(); tick(); save_req = 1'b0;
        resolve(2'd0, 1'b0); tick();
        resolve(2'd2, 1'b1); tick();
        chk("youngmp_occ", occupancy, 1);
        chk("youngmp_cv", column_valid, 4'b0010);
        chk("youngmp_restore_column", restore_column, 2);
        resolve_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
